alimentador_anillo: RTL
=======================

Name: alimentador_anillo

Overview:
Matrix feeder for the systolic ring (`unidad`). It stores an N x N coefficient matrix written over a simple write port. On `start` it streams the matrix into the ring's `a1..a4` inputs in diagonal-skewed order, one beat per advance cycle. It is the producer end of the ring's `a`-operand interface; `x1..x4` stay static and are not handled here.

Parameters:
- WIDTH, 16, bit width of each matrix element and each `a` output.
- N, 4, ring size (number of PEs and matrix dimension); this block is fixed at 4 outputs, so N=4 only.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- wr_en  in  1  matrix write strobe.
- wr_row  in  2  row index i of the write.
- wr_col  in  2  column index j of the write.
- wr_data  in  WIDTH  element value M[i][j].
- start  in  1  request to stream the stored matrix.
- stall  in  1  ring not advancing this cycle; hold the current beat.
- a1, a2, a3, a4  out  WIDTH each  registered operands to PE1..PE4.
- a_valid  out  1  a1..a4 carry a live beat.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the last beat is consumed.

Behaviour:
- Reset (reset=0, async):
  - matrix storage cleared to 0.
  - a1..a4=0, a_valid=0, busy=0, done=0.
  - state=IDLE, step counter paso=0.
- Beat k (k=0..N-1) definition:
  - a(p) = M[p-1][(p-1+k) mod N] for p=1..4.
  - Column index wraps modulo N.
- Matrix writes:
  - Committed at the edge when wr_en=1, state=IDLE and start=0.
  - Ignored in RUN and in the cycle a start is accepted.
  - Write data is visible to the next run.
- State IDLE:
  - a_valid=0, busy=0, a1..a4 held at 0.
  - On an edge with start=1: load beat 0 into a1..a4, set a_valid=1, busy=1, paso=1, go to RUN.
  - Latency: first beat valid one cycle after start is sampled.
  - stall is ignored in IDLE.
- State RUN, edge with stall=1:
  - All registers hold; the same beat is presented again.
- State RUN, edge with stall=0:
  - If paso<N: load beat paso, paso++.
  - If paso==N: a1..a4=0, a_valid=0, busy=0, done=1, paso=0, go to IDLE.
- Run timing with no stalls: a_valid is high for exactly N cycles; done rises in the cycle after the last beat.
- done behaviour: cleared on the following edge, so it is a single-cycle pulse.
- start in RUN: ignored, no queuing.
- start in the cycle done=1: accepted (state is already IDLE), so runs can be back-to-back with one idle cycle between them.
- Reset mid-run: aborts immediately to the reset state; matrix contents are lost.
- Arithmetic: none on data. paso is a 3-bit counter (0..N). The column index is formed as a 2-bit sum with natural wrap.

Decomposition:
- Shared package `anillo_pkg`:
  - WIDTH and N constants.
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - Index-width constant clog2(N)=2.
- One sub-module `memoria_coef`:
  - N x N register file with synchronous write and 4 combinational read ports.
  - Read address for port p = {p-1, p-1+paso}.
- Top block holds the FSM, the counter and the output registers.

Test Plan:
- Reset then idle: hold reset=0 for 50ns, then release -> all outputs 0; start never given -> a_valid stays 0 for 10 cycles.
- Load and stream: write rows 1,2,3,4 / 5,6,7,8 / 9,10,11,12 / 13,14,15,16, then pulse start. Required beats:
  - (1,6,11,16)
  - (2,7,12,13)
  - (3,8,9,14)
  - (4,5,10,15)
  - then done=1 for one cycle, busy=0.
- Stall: same matrix, stall=1 during beat 1 for 3 cycles -> (2,7,12,13) held for 4 cycles total; done is delayed by 3 cycles.
- Ignored write/start: wr_en to M[0][0]=0xFFFF and start=1 during RUN -> current stream unchanged; next run's beat 0 has a1=1; no extra run occurs.
- Back-to-back: start asserted in the done cycle -> a new beat (1,6,11,16) appears on the next cycle.
- Reset mid-run: reset=0 during beat 2 -> outputs 0 immediately; after release, start gives beat 0 = (0,0,0,0).

Source files
------------

// File: rtl/alimentador_anillo_pkg.sv
// Shared constants and types for the ring matrix feeder.
package anillo_pkg;
   localparam int WIDTH  = 16;
   localparam int N      = 4;
   localparam int IDX_W  = $clog2(N);
   localparam int PASO_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } estado_t;
endpackage

// File: rtl/alimentador_anillo_if.sv
// Host-side write/start port and ring-side a-operand outputs of the feeder.
interface alimentador_anillo_if #(
   parameter int WIDTH = anillo_pkg::WIDTH
);
   logic                       wr_en;
   logic [anillo_pkg::IDX_W-1:0] wr_row;
   logic [anillo_pkg::IDX_W-1:0] wr_col;
   logic [WIDTH-1:0]           wr_data;
   logic                       start;
   logic                       stall;
   logic [WIDTH-1:0]           a1;
   logic [WIDTH-1:0]           a2;
   logic [WIDTH-1:0]           a3;
   logic [WIDTH-1:0]           a4;
   logic                       a_valid;
   logic                       busy;
   logic                       done;

   modport master (
      output wr_en, wr_row, wr_col, wr_data, start, stall,
      input  a1, a2, a3, a4, a_valid, busy, done
   );

   modport slave (
      input  wr_en, wr_row, wr_col, wr_data, start, stall,
      output a1, a2, a3, a4, a_valid, busy, done
   );
endinterface

// File: rtl/alimentador_anillo_memoria.sv
// N x N coefficient register file; port p reads the diagonal element of row p.
module memoria_coef
   import anillo_pkg::*;
#(
   parameter int WIDTH = anillo_pkg::WIDTH,
   parameter int N     = anillo_pkg::N
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we,
   input  logic [IDX_W-1:0]          w_row,
   input  logic [IDX_W-1:0]          w_col,
   input  logic [WIDTH-1:0]          w_data,
   input  logic [IDX_W-1:0]          paso,
   output logic [N-1:0][WIDTH-1:0]   rd
);

   logic [N-1:0][N-1:0][WIDTH-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[w_row][w_col] = w_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) mem_q <= '0;
      else        mem_q <= mem_d;
   end

   // Column index wraps naturally in IDX_W bits, giving the mod-N skew.
   for (genvar p = 0; p < N; p++) begin : g_rd
      logic [IDX_W-1:0] col;
      assign col   = IDX_W'(p) + paso;
      assign rd[p] = mem_q[p][col];
   end

endmodule

// File: rtl/alimentador_anillo.sv
// Streams the stored matrix into the ring's a-inputs in diagonal-skewed beats.
module alimentador_anillo
   import anillo_pkg::*;
#(
   parameter int WIDTH = anillo_pkg::WIDTH,
   parameter int N     = anillo_pkg::N
) (
   input  logic                 clk,
   input  logic                 reset,
   alimentador_anillo_if.slave  bus
);

   estado_t                   state_q, state_d;
   logic [PASO_W-1:0]         paso_q, paso_d;
   logic [N-1:0][WIDTH-1:0]   a_q, a_d;
   logic                      a_valid_q, a_valid_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic [N-1:0][WIDTH-1:0]   rd;
   logic                      we;
   logic                      ultimo;

   // Writes only land while idle and not in the same edge a run begins.
   assign we     = bus.wr_en && (state_q == IDLE) && !bus.start;
   assign ultimo = (paso_q == PASO_W'(N));

   memoria_coef #(.WIDTH(WIDTH), .N(N)) u_mem (
      .clk    (clk),
      .reset  (reset),
      .we     (we),
      .w_row  (bus.wr_row),
      .w_col  (bus.wr_col),
      .w_data (bus.wr_data),
      .paso   (paso_q[IDX_W-1:0]),
      .rd     (rd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         paso_q    <= '0;
         a_q       <= '0;
         a_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         paso_q    <= paso_d;
         a_q       <= a_d;
         a_valid_q <= a_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (!bus.stall && ultimo) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A stalled RUN cycle keeps every register, so the beat is re-presented.
   always_comb begin
      paso_d    = paso_q;
      a_d       = a_q;
      a_valid_d = a_valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d       = rd;
               a_valid_d = 1'b1;
               busy_d    = 1'b1;
               paso_d    = PASO_W'(1);
            end
         end
         RUN: begin
            if (!bus.stall) begin
               if (ultimo) begin
                  a_d       = '0;
                  a_valid_d = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  paso_d    = '0;
               end else begin
                  a_d    = rd;
                  paso_d = paso_q + PASO_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.a1      = a_q[0];
   assign bus.a2      = a_q[1];
   assign bus.a3      = a_q[2];
   assign bus.a4      = a_q[3];
   assign bus.a_valid = a_valid_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
